act_requant_buf: RTL
====================

// Module: act_requant_buf
// PURPOSE
//  Downstream stage of the bias accumulator. Consumes one 22-bit signed neuron sum per valid beat
//  and applies arithmetic scaling, optional ReLU and saturation to 8-bit signed. Stores the results
//  in a per-layer output buffer that the next layer's MAC reads, and tracks a running argmax used
//  as the digit decision on the final layer.
// PARAMETERS
//  ACC_W        22   width of incoming accumulator sum (signed)
//  OUT_W         8   width of requantised activation (signed, matches MAC input width)
//  NUM_NEURONS  10   neurons per layer = buffer depth
//  SHIFT         7   arithmetic right-shift applied to the sum (1..ACC_W-OUT_W)
//  IDX_W         4   index width, $clog2(NUM_NEURONS)
// PORTS
//  clk        in   1        rising-edge clock
//  reset      in   1        asynchronous, active-low reset
//  start      in   1        1-cycle pulse: begin new layer (clears count, argmax, err)
//  relu_en    in   1        1 = ReLU on (hidden layers), 0 = linear (output layer)
//  acc_valid  in   1        acc_in carries a finished neuron sum this cycle
//  acc_in     in   ACC_W    signed neuron sum incl. bias
//  rd_addr    in   IDX_W    buffer read index
//  rd_data    out  OUT_W    registered buffer read data
//  busy       out  1        layer in progress (ACTIVE or DRAIN)
//  layer_done out  1        1-cycle pulse: all NUM_NEURONS results written
//  max_idx    out  IDX_W    index of largest activation (valid when DONE)
//  max_val    out  OUT_W    largest activation value
//  ovf_err    out  1        sticky: acc_valid arrived when not ACTIVE
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; count, rd_data, max_idx, max_val, busy, layer_done,
//   ovf_err = 0; buffer contents are don't-care.
//  FSM: IDLE -start-> ACTIVE; ACTIVE -(NUM_NEURONS-th beat accepted)-> DRAIN;
//   DRAIN -(pipeline empty, 2 cycles)-> DONE (layer_done=1 for that cycle); DONE -start-> ACTIVE.
//  Pipeline: S1 (registered) = acc_in>>>SHIFT (floor, no rounding), then ReLU if relu_en and
//   result<0 -> 0. S2 (registered) = saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1], write buf[count],
//   update argmax. A beat accepted at edge t is written at edge t+2.
//  Argmax: the first result of the layer loads unconditionally; later results replace it only if
//   strictly greater, so ties keep the lowest index.
//  rd_data = buf[rd_addr], registered, 1-cycle latency. Reading an address being written in the
//   same cycle returns the old value. rd_addr >= NUM_NEURONS returns 0.
//  acc_valid in IDLE/DRAIN/DONE: beat dropped, ovf_err set (sticky until start or reset).
//  start in any state: in-flight S1/S2 beats discarded, count/argmax/ovf_err cleared, state=ACTIVE.
//   An acc_valid coincident with start is accepted as neuron 0 of the new layer.
//  relu_en is sampled with each beat; changing it mid-layer affects subsequent beats only.
//  busy=1 in ACTIVE and DRAIN. layer_done never asserts without NUM_NEURONS accepted beats.
//  Reset deasserted mid-layer: restarts in IDLE. The upstream stage must re-issue start.
// STRUCTURE
//  Shared package nn_pkg: ACC_W, OUT_W, state encoding (IDLE/ACTIVE/DRAIN/DONE), sat_signed()
//   function; the MAC, accumulator and this block all import it.
//  Sub-module act_requant: combinational shift, ReLU and saturate (acc_in, relu_en -> OUT_W
//   value), instantiated between the S1/S2 registers. FSM, counter, buffer and argmax live in
//   the top module.
// TESTING (SHIFT=7, NUM_NEURONS=10)
//  Reset mid-layer after 4 beats -> all outputs 0, state IDLE; next start + 10 beats gives
//   normal done.
//  start, relu_en=1, acc_in=4096 -> buf[0]=32 two edges later; rd_addr=0 -> rd_data=32 one
//   cycle later.
//  relu_en=1, acc_in=-300 -> 0; relu_en=0, acc_in=-300 -> -3 (floor); acc_in=20000 -> 127;
//   acc_in=-20000 -> -128.
//  10 back-to-back beats, values 5,90,90,-7,... -> layer_done pulse exactly 3 cycles after the
//   10th beat; max_idx=1, max_val=90 (tie keeps lowest index).
//  acc_valid in DONE -> ovf_err=1, buffer unchanged; next start -> ovf_err=0.
//  start coincident with acc_valid while 2 beats are in flight -> in-flight beats discarded,
//   coincident beat becomes buf[0], count=1.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared numeric definitions for the MAC / accumulator / requantisation datapath.
// Provides the sum and activation widths, the layer FSM encoding and saturation.
package nn_pkg;

    localparam int ACC_W = 22;
    localparam int OUT_W = 8;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Clamp a wide signed value into the OUT_W signed range.
    function automatic logic signed [OUT_W-1:0] sat_signed(input logic signed [ACC_W-1:0] x);
        logic signed [OUT_W-1:0] r;
        if (x > SAT_MAX) begin
            r = SAT_MAX[OUT_W-1:0];
        end else if (x < SAT_MIN) begin
            r = SAT_MIN[OUT_W-1:0];
        end else begin
            r = x[OUT_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/act_requant_buf_if.sv
// Bundle between the bias accumulator / next-layer MAC and the requantisation buffer.
// master drives sums and read addresses; slave is the buffer itself.
interface act_requant_buf_if #(
    parameter int IDX_W = 4
);
    import nn_pkg::*;

    logic                    start;
    logic                    relu_en;
    logic                    acc_valid;
    logic signed [ACC_W-1:0] acc_in;
    logic [IDX_W-1:0]        rd_addr;
    logic signed [OUT_W-1:0] rd_data;
    logic                    busy;
    logic                    layer_done;
    logic [IDX_W-1:0]        max_idx;
    logic signed [OUT_W-1:0] max_val;
    logic                    ovf_err;

    modport master (
        output start, relu_en, acc_valid, acc_in, rd_addr,
        input  rd_data, busy, layer_done, max_idx, max_val, ovf_err
    );

    modport slave (
        input  start, relu_en, acc_valid, acc_in, rd_addr,
        output rd_data, busy, layer_done, max_idx, max_val, ovf_err
    );

endinterface

// File: rtl/act_requant.sv
// Combinational requantisation: floor shift, optional ReLU, saturate to OUT_W signed.
module act_requant
    import nn_pkg::*;
#(
    parameter int SHIFT = 7
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic                    relu_en,
    output logic signed [OUT_W-1:0] act
);

    logic signed [ACC_W-1:0] shifted;
    logic signed [ACC_W-1:0] rect;

    // Arithmetic shift floors toward minus infinity, so -300 >>> 7 gives -3.
    always_comb begin
        shifted = acc >>> SHIFT;
        rect    = (relu_en && shifted[ACC_W-1]) ? '0 : shifted;
        act     = sat_signed(rect);
    end

endmodule

// File: rtl/act_requant_buf.sv
// Requantises one neuron sum per beat into a per-layer activation buffer,
// tracking a running argmax and a sticky error for beats outside a layer.
module act_requant_buf
    import nn_pkg::*;
#(
    parameter int NUM_NEURONS = 10,
    parameter int SHIFT       = 7,
    parameter int IDX_W       = 4
) (
    input logic              clk,
    input logic              reset,
    act_requant_buf_if.slave bus
);

    state_t state, state_nxt;

    logic [IDX_W-1:0]        count;
    logic [IDX_W-1:0]        beat_idx;
    logic                    accept;
    logic                    last_beat;
    logic                    wr_en;

    logic                    s1_valid;
    logic signed [ACC_W-1:0] s1_acc;
    logic                    s1_relu;
    logic [IDX_W-1:0]        s1_idx;

    logic                    s2_valid;
    logic signed [OUT_W-1:0] s2_val;
    logic [IDX_W-1:0]        s2_idx;
    logic signed [OUT_W-1:0] req_val;

    logic                    have_max;
    logic [IDX_W-1:0]        max_idx_q;
    logic signed [OUT_W-1:0] max_val_q;
    logic signed [OUT_W-1:0] rd_data_q;
    logic                    layer_done_q;
    logic                    ovf_err_q;
    logic                    busy_c;

    logic signed [OUT_W-1:0] buf_mem [NUM_NEURONS];

    // A start restarts the layer, so a coincident beat always lands at index 0.
    assign accept    = bus.acc_valid && (bus.start || state == ACTIVE);
    assign beat_idx  = bus.start ? '0 : count;
    assign last_beat = accept && (beat_idx == IDX_W'(NUM_NEURONS - 1));
    assign wr_en     = s2_valid && !bus.start;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        busy_c    = 1'b0;
        if (bus.start) begin
            state_nxt = last_beat ? DRAIN : ACTIVE;
        end else begin
            case (state)
                ACTIVE:  if (last_beat) state_nxt = DRAIN;
                DRAIN:   if (!s1_valid) state_nxt = DONE;
                default: state_nxt = state;
            endcase
        end
        if (state == ACTIVE || state == DRAIN) begin
            busy_c = 1'b1;
        end
    end

    act_requant #(
        .SHIFT (SHIFT)
    ) u_requant (
        .acc     (s1_acc),
        .relu_en (s1_relu),
        .act     (req_val)
    );

    // NOTE: state registers use non-blocking assignments so every process sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            s1_valid <= 1'b0;
            s1_acc   <= '0;
            s1_relu  <= 1'b0;
            s1_idx   <= '0;
            s2_valid <= 1'b0;
            s2_val   <= '0;
            s2_idx   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_acc  <= bus.acc_in;
                s1_relu <= bus.relu_en;
                s1_idx  <= beat_idx;
            end
            s2_valid <= s1_valid && !bus.start;
            s2_val   <= req_val;
            s2_idx   <= s1_idx;
            if (bus.start) begin
                count <= bus.acc_valid ? IDX_W'(1) : '0;
            end else if (accept) begin
                count <= count + 1'b1;
            end
        end
    end

    // First result of a layer loads unconditionally; ties keep the lower index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            have_max     <= 1'b0;
            max_idx_q    <= '0;
            max_val_q    <= '0;
            ovf_err_q    <= 1'b0;
            layer_done_q <= 1'b0;
        end else begin
            layer_done_q <= (state == DRAIN) && (state_nxt == DONE);
            if (bus.start) begin
                have_max  <= 1'b0;
                max_idx_q <= '0;
                max_val_q <= '0;
                ovf_err_q <= 1'b0;
            end else begin
                if (bus.acc_valid && state != ACTIVE) begin
                    ovf_err_q <= 1'b1;
                end
                if (wr_en && (!have_max || s2_val > max_val_q)) begin
                    have_max  <= 1'b1;
                    max_idx_q <= s2_idx;
                    max_val_q <= s2_val;
                end
            end
        end
    end

    // NOTE: the buffer has no reset; its contents are only meaningful once written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_mem[s2_idx] <= s2_val;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_q <= '0;
        end else if (int'(bus.rd_addr) < NUM_NEURONS) begin
            rd_data_q <= buf_mem[bus.rd_addr];
        end else begin
            rd_data_q <= '0;
        end
    end

    assign bus.rd_data    = rd_data_q;
    assign bus.busy       = busy_c;
    assign bus.layer_done = layer_done_q;
    assign bus.max_idx    = max_idx_q;
    assign bus.max_val    = max_val_q;
    assign bus.ovf_err    = ovf_err_q;

endmodule
